// File: rtl/mcpu_regfile_mp_pkg.sv
// Shared definitions for the MCPU multi-port register file: dump FSM state
// encodings and the default datapath widths used across the MCPU.
package mcpu_regfile_mp_pkg;

  localparam int MCPU_DATA_WIDTH = 8;
  localparam int MCPU_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_RUN  = 2'd1,
    DUMP_DONE = 2'd2
  } dump_state_e;

endpackage

// File: rtl/mcpu_regfile_mp_dump_fsm.sv
// Dump engine for the register file: walks a pointer over every register with
// a valid/ready handshake and signals completion with a one-cycle pulse.
module mcpu_regfile_mp_dump_fsm
  import mcpu_regfile_mp_pkg::*;
#(
  parameter int ADDR_WIDTH = MCPU_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dump_start,
  input  logic                  dump_ready,
  output logic                  dump_valid,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  output logic                  dump_done,
  output logic                  busy
);

  dump_state_e           state, state_next;
  logic [ADDR_WIDTH-1:0] ptr, ptr_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= DUMP_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    dump_valid = 1'b0;
    dump_done  = 1'b0;
    case (state)
      DUMP_IDLE: begin
        if (dump_start) begin
          state_next = DUMP_RUN;
          ptr_next   = '0;
        end
      end
      DUMP_RUN: begin
        dump_valid = 1'b1;
        // The last beat moves to DONE instead of wrapping the pointer.
        if (dump_ready) begin
          if (ptr == '1) state_next = DUMP_DONE;
          else           ptr_next   = ptr + 1'b1;
        end
      end
      DUMP_DONE: begin
        dump_done  = 1'b1;
        ptr_next   = '0;
        state_next = DUMP_IDLE;
      end
      default: state_next = DUMP_IDLE;
    endcase
  end

  assign dump_addr = ptr;
  assign busy      = (state != DUMP_IDLE);

endmodule

// File: rtl/mcpu_regfile_mp.sv
// Parametrised multi-port register file for the MCPU: two write ports, NUM_RD
// combinational read ports, optional bypass and hardwired R0, plus a dump engine.
module mcpu_regfile_mp
  import mcpu_regfile_mp_pkg::*;
#(
  parameter int DATA_WIDTH = MCPU_DATA_WIDTH,
  parameter int ADDR_WIDTH = MCPU_ADDR_WIDTH,
  parameter int NUM_RD     = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         we0,
  input  logic [ADDR_WIDTH-1:0]        waddr0,
  input  logic [DATA_WIDTH-1:0]        wdata0,
  input  logic                         we1,
  input  logic [ADDR_WIDTH-1:0]        waddr1,
  input  logic [DATA_WIDTH-1:0]        wdata1,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  input  logic                         clr,
  input  logic                         dump_start,
  input  logic                         dump_ready,
  output logic                         dump_valid,
  output logic [ADDR_WIDTH-1:0]        dump_addr,
  output logic [DATA_WIDTH-1:0]        dump_data,
  output logic                         dump_done,
  output logic                         busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam bit BYP   = (BYPASS != 0);
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_WIDTH-1:0] regs [DEPTH];

  // Port 1 is written last so it wins a same-address collision; R0 stays
  // untouched when it is hardwired to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (we0 && !(ZR && waddr0 == '0)) regs[waddr0] <= wdata0;
      if (we1 && !(ZR && waddr1 == '0)) regs[waddr1] <= wdata1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] value;

    assign addr = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

    // A pending clear means the write data never lands, so bypass is skipped.
    always_comb begin
      value = regs[addr];
      if (BYP && !clr) begin
        if (we1 && waddr1 == addr)      value = wdata1;
        else if (we0 && waddr0 == addr) value = wdata0;
      end
      if (ZR && addr == '0) value = '0;
    end

    assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = value;
  end

  mcpu_regfile_mp_dump_fsm #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_dump (
    .clk       (clk),
    .reset     (reset),
    .dump_start(dump_start),
    .dump_ready(dump_ready),
    .dump_valid(dump_valid),
    .dump_addr (dump_addr),
    .dump_done (dump_done),
    .busy      (busy)
  );

  // Dump beats read the array directly so stalled beats see late writes.
  assign dump_data = (ZR && dump_addr == '0) ? '0 : regs[dump_addr];

endmodule

// File: tb/tb_mcpu_regfile_mp.sv
// Self-checking bench for mcpu_regfile_mp: three configurations share stimulus
// (default, bypass off, hardwired R0); dump beats are scored through a queue.
module tb_mcpu_regfile_mp;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NR = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic we0 = 1'b0, we1 = 1'b0, clr = 1'b0;
  logic dumpStart = 1'b0, dumpReady = 1'b0;
  logic [AW-1:0] waddr0 = '0, waddr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic [NR*AW-1:0] rdAddr = '0;

  logic [NR*DW-1:0] rdDataA, rdDataB, rdDataC;
  logic dumpValidA, dumpValidB, dumpValidC;
  logic [AW-1:0] dumpAddrA, dumpAddrB, dumpAddrC;
  logic [DW-1:0] dumpDataA, dumpDataB, dumpDataC;
  logic dumpDoneA, dumpDoneB, dumpDoneC;
  logic busyA, busyB, busyC;

  int checkCount = 0;
  int errorCount = 0;
  int beatCount = 0;
  int doneCount = 0;
  bit monitorOn = 1'b0;
  beat_t expQ[$];
  beat_t expBeat;

  always #5 clk = ~clk;

  mcpu_regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .BYPASS(1), .ZERO_REG(0)) dutA (
    .clk(clk), .reset(reset), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .rd_addr(rdAddr), .rd_data(rdDataA),
    .clr(clr), .dump_start(dumpStart), .dump_ready(dumpReady), .dump_valid(dumpValidA),
    .dump_addr(dumpAddrA), .dump_data(dumpDataA), .dump_done(dumpDoneA), .busy(busyA));

  mcpu_regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .BYPASS(0), .ZERO_REG(0)) dutB (
    .clk(clk), .reset(reset), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .rd_addr(rdAddr), .rd_data(rdDataB),
    .clr(clr), .dump_start(dumpStart), .dump_ready(dumpReady), .dump_valid(dumpValidB),
    .dump_addr(dumpAddrB), .dump_data(dumpDataB), .dump_done(dumpDoneB), .busy(busyB));

  mcpu_regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .BYPASS(1), .ZERO_REG(1)) dutC (
    .clk(clk), .reset(reset), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .rd_addr(rdAddr), .rd_data(rdDataC),
    .clr(clr), .dump_start(dumpStart), .dump_ready(dumpReady), .dump_valid(dumpValidC),
    .dump_addr(dumpAddrC), .dump_data(dumpDataC), .dump_done(dumpDoneC), .busy(busyC));

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    we0 = e0; waddr0 = a0; wdata0 = d0;
    we1 = e1; waddr1 = a1; wdata1 = d1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for dump_done on instance A, returning elapsed negedges.
  task automatic waitDone(output bit gotDone, output int cycles);
    gotDone = 1'b0;
    cycles = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cycles++;
      if (dumpDoneA) begin
        gotDone = 1'b1;
        break;
      end
    end
  endtask

  // Scoreboard side: every accepted beat pops one expected entry.
  always @(negedge clk) begin
    if (dumpDoneA) doneCount++;
    if (monitorOn && reset && dumpValidA && dumpReady) begin
      if (expQ.size() == 0) begin
        checkOutput("dump_extra_beat", 32'(expQ.size()), 32'd1);
      end else begin
        expBeat = expQ.pop_front();
        checkOutput("dump_addr", 32'(dumpAddrA), 32'(expBeat.addr));
        checkOutput("dump_data", 32'(dumpDataA), 32'(expBeat.data));
        beatCount++;
      end
    end
  end

  initial begin
    bit gotDone;
    int cycles;
    int doneSnap;

    #12;
    checkOutput("reset_rd0", 32'(rdDataA[DW-1:0]), 32'h0);
    checkOutput("reset_busy", 32'(busyA), 32'h0);
    checkOutput("reset_valid", 32'(dumpValidA), 32'h0);
    checkOutput("reset_done", 32'(dumpDoneA), 32'h0);
    checkOutput("reset_dump_addr", 32'(dumpAddrA), 32'h0);
    tick();
    reset = 1'b1;

    // Load R5 and then reset asynchronously in the middle of a cycle.
    applyStimulus(1'b1, 4'd5, 8'h21, 1'b0, 4'd0, 8'h00);
    rdAddr = {4'd0, 4'd5};
    tick();
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00);
    #1 checkOutput("r5_loaded", 32'(rdDataA[DW-1:0]), 32'h21);
    #2 reset = 1'b0;
    #1 checkOutput("r5_async_reset", 32'(rdDataA[DW-1:0]), 32'h0);
    checkOutput("async_reset_busy", 32'(busyA), 32'h0);
    checkOutput("async_reset_valid", 32'(dumpValidA), 32'h0);
    tick();
    reset = 1'b1;

    // Same-address collision on both write ports.
    tick();
    applyStimulus(1'b1, 4'd3, 8'h11, 1'b1, 4'd3, 8'h22);
    rdAddr = {4'd3, 4'd3};
    #1 checkOutput("collide_bypass_p0", 32'(rdDataA[DW-1:0]), 32'h22);
    checkOutput("collide_bypass_p1", 32'(rdDataA[2*DW-1:DW]), 32'h22);
    tick();
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00);
    #1 checkOutput("collide_after_a", 32'(rdDataA[DW-1:0]), 32'h22);
    checkOutput("collide_after_b", 32'(rdDataB[DW-1:0]), 32'h22);

    // Bypass on versus off for a write to R10.
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b1, 4'd10, 8'h21);
    rdAddr = {4'd0, 4'd10};
    #1 checkOutput("nobypass_write_cycle", 32'(rdDataB[DW-1:0]), 32'h0);
    checkOutput("bypass_write_cycle", 32'(rdDataA[DW-1:0]), 32'h21);
    tick();
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00);
    #1 checkOutput("nobypass_next_cycle", 32'(rdDataB[DW-1:0]), 32'h21);

    // Full dump with Rk = k+1 and ready held high.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 4'(2*k), 8'(2*k+1), 1'b1, 4'(2*k+1), 8'(2*k+2));
      tick();
    end
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00);
    for (int k = 0; k < 16; k++) expQ.push_back('{addr: 4'(k), data: 8'(k+1)});
    beatCount = 0;
    monitorOn = 1'b1;
    dumpReady = 1'b1;
    dumpStart = 1'b1;
    tick();
    dumpStart = 1'b0;
    waitDone(gotDone, cycles);
    checkOutput("dump1_done_seen", 32'(gotDone), 32'h1);
    checkOutput("dump1_cycles", 32'(cycles), 32'd17);
    checkOutput("dump1_beats", 32'(beatCount), 32'd16);
    checkOutput("dump1_queue_left", 32'(expQ.size()), 32'd0);
    @(negedge clk);
    checkOutput("dump1_done_one_cycle", 32'(dumpDoneA), 32'h0);
    checkOutput("dump1_idle_busy", 32'(busyA), 32'h0);

    // Backpressure at beat 4 while R4 is overwritten.
    tick();
    for (int k = 0; k < 16; k++) expQ.push_back('{addr: 4'(k), data: (k == 4) ? 8'hFF : 8'(k+1)});
    beatCount = 0;
    dumpStart = 1'b1;
    tick();
    dumpStart = 1'b0;
    gotDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (dumpValidA && dumpAddrA == 4'd4) begin
        gotDone = 1'b1;
        break;
      end
      tick();
    end
    checkOutput("bp_reached_beat4", 32'(gotDone), 32'h1);
    dumpReady = 1'b0;
    applyStimulus(1'b1, 4'd4, 8'hFF, 1'b0, 4'd0, 8'h00);
    #1 checkOutput("bp_stall1_addr", 32'(dumpAddrA), 32'd4);
    tick();
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00);
    #1 checkOutput("bp_stall2_addr", 32'(dumpAddrA), 32'd4);
    checkOutput("bp_stall2_data", 32'(dumpDataA), 32'hFF);
    tick();
    #1 checkOutput("bp_stall3_addr", 32'(dumpAddrA), 32'd4);
    checkOutput("bp_stall3_valid", 32'(dumpValidA), 32'h1);
    dumpReady = 1'b1;
    waitDone(gotDone, cycles);
    checkOutput("dump2_done_seen", 32'(gotDone), 32'h1);
    checkOutput("dump2_beats", 32'(beatCount), 32'd16);
    checkOutput("dump2_queue_left", 32'(expQ.size()), 32'd0);
    monitorOn = 1'b0;

    // Hardwired R0: write is ignored on every path.
    tick();
    applyStimulus(1'b1, 4'd0, 8'h55, 1'b0, 4'd0, 8'h00);
    rdAddr = {4'd2, 4'd0};
    #1 checkOutput("zr_r0_bypass", 32'(rdDataC[DW-1:0]), 32'h0);
    tick();
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00);
    #1 checkOutput("zr_r0_after", 32'(rdDataC[DW-1:0]), 32'h0);
    checkOutput("nozr_r0_after", 32'(rdDataA[DW-1:0]), 32'h55);

    // Clear beats a concurrent write and suppresses bypass.
    clr = 1'b1;
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b1, 4'd2, 8'h77);
    #1 checkOutput("clr_preclear_a", 32'(rdDataA[2*DW-1:DW]), 32'h3);
    checkOutput("clr_preclear_c", 32'(rdDataC[2*DW-1:DW]), 32'h3);
    tick();
    clr = 1'b0;
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00);
    #1 checkOutput("clr_r2_a", 32'(rdDataA[2*DW-1:DW]), 32'h0);
    checkOutput("clr_r2_c", 32'(rdDataC[2*DW-1:DW]), 32'h0);

    // Reset during RUN aborts the dump without a done pulse.
    doneSnap = doneCount;
    dumpReady = 1'b1;
    dumpStart = 1'b1;
    tick();
    dumpStart = 1'b0;
    tick();
    tick();
    checkOutput("run_busy", 32'(busyA), 32'h1);
    reset = 1'b0;
    #1 checkOutput("run_reset_busy", 32'(busyA), 32'h0);
    checkOutput("run_reset_valid", 32'(dumpValidA), 32'h0);
    checkOutput("run_reset_busy_c", 32'(busyC), 32'h0);
    tick();
    reset = 1'b1;
    repeat (25) tick();
    checkOutput("run_reset_no_done", 32'(doneCount - doneSnap), 32'd0);
    checkOutput("run_reset_idle", 32'(busyA), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
